// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the pc, drives the ROM address and presents
// one captured instruction at a time over a valid/ready handshake.
// Optional breakpoint support is enabled by defining FETCH_SEQ_BKPT_EN.
module fetch_sequencer #(
  parameter int unsigned PROG_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic       halt_req,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_target,
  output logic       running,
`ifdef FETCH_SEQ_BKPT_EN
  input  logic       bp_en,
  input  logic [7:0] bp_addr,
  output logic       bp_hit,
`endif
  output logic       done
);

  localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic       instr_valid_q, instr_valid_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       done_q, done_d;
  logic       slot_free;
  logic       fetch;
`ifdef FETCH_SEQ_BKPT_EN
  logic       skip_bp_q, skip_bp_d;
  logic       bp_hit_q, bp_hit_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HALT;
      pc_q          <= 8'd0;
      instr_q       <= 8'd0;
      instr_pc_q    <= 8'd0;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef FETCH_SEQ_BKPT_EN
      skip_bp_q     <= 1'b0;
      bp_hit_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
      wrap_q        <= wrap_d;
      done_q        <= done_d;
`ifdef FETCH_SEQ_BKPT_EN
      skip_bp_q     <= skip_bp_d;
      bp_hit_q      <= bp_hit_d;
`endif
    end
  end

  // Control priority: redirect, halt_req, start, step, then fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    wrap_d        = 1'b0;
    done_d        = wrap_q;
    fetch         = 1'b0;
    slot_free     = !instr_valid_q || instr_ready;
`ifdef FETCH_SEQ_BKPT_EN
    skip_bp_d     = skip_bp_q;
    bp_hit_d      = 1'b0;
`endif

    if (instr_valid_q && instr_ready) instr_valid_d = 1'b0;

    if (redirect_valid) begin
      pc_d          = (32'(redirect_target) >= PROG_LEN) ? 8'd0 : redirect_target;
      instr_valid_d = 1'b0;
`ifdef FETCH_SEQ_BKPT_EN
      skip_bp_d     = 1'b0;
`endif
    end else if (halt_req) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_HALT: begin
          if (start) begin
            state_d = S_RUN;
`ifdef FETCH_SEQ_BKPT_EN
            skip_bp_d = 1'b1;
`endif
          end else if (step) begin
            state_d = S_STEP;
`ifdef FETCH_SEQ_BKPT_EN
            skip_bp_d = 1'b1;
`endif
          end
        end
        S_RUN, S_STEP: begin
          if (slot_free) begin
`ifdef FETCH_SEQ_BKPT_EN
            if (state_q == S_RUN && bp_en && pc_q == bp_addr && !skip_bp_q) begin
              state_d  = S_HALT;
              bp_hit_d = 1'b1;
            end else begin
              fetch = 1'b1;
            end
`else
            fetch = 1'b1;
`endif
          end
        end
        default: state_d = S_HALT;
      endcase
    end

    if (fetch) begin
      instr_d       = rom_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
`ifdef FETCH_SEQ_BKPT_EN
      skip_bp_d     = 1'b0;
`endif
      if (state_q == S_STEP) state_d = S_HALT;
      if (pc_q == LAST_PC) begin
        pc_d    = 8'd0;
        wrap_d  = 1'b1;
        state_d = S_HALT;
      end else begin
        pc_d = pc_q + 8'd1;
      end
    end

    running_d = (state_d != S_HALT);
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign running     = running_q;
  assign done        = done_q;
`ifdef FETCH_SEQ_BKPT_EN
  assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the 8-bit program ROM and the decode/execute stage of the cpu2 core. It owns the program counter, drives the ROM line address, and captures each instruction into a one-entry output register with a valid/ready handshake. Execute redirects it on taken jumps, and an external debug controller starts, halts and single-steps it.

## Interface
- PROG_LEN, 64: number of valid ROM lines; legal range 2..256.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; enter RUN from HALT
- step  in  1  pulse; fetch exactly one instruction from HALT
- halt_req  in  1  level; stop fetching
- rom_addr  out  8  ROM line address, equals pc; ROM is combinational
- rom_data  in  8  instruction at rom_addr, same cycle
- instr  out  8  captured instruction
- instr_pc  out  8  address instr was fetched from
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  execute accepts instr this cycle
- redirect_valid  in  1  taken jump; only legal with instr_valid & instr_ready
- redirect_target  in  8  jump destination line
- running  out  1  state is RUN or STEP
- done  out  1  one-cycle pulse after line PROG_LEN-1 is fetched
- bp_en, bp_addr, bp_hit  in 1 / in 8 / out 1  present only with FETCH_SEQ_BKPT_EN

## Operation
- States: HALT, RUN, STEP. Reset state is HALT.
- Slot free this cycle = !instr_valid | instr_ready.
- Fetch = running & slot free & !halt_req & !redirect_valid. On fetch: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
- If a consume happens without a fetch, instr_valid<=0. A held instruction persists across HALT until consumed.
- HALT: start -> RUN; else step -> STEP; if both, start wins. No fetch occurs in the cycle of the transition.
- RUN: halt_req -> HALT with no fetch that cycle.
- STEP: on the first fetch -> HALT. halt_req in STEP -> HALT with no fetch.
- End of program: a fetch from pc==PROG_LEN-1 sets pc<=0, pulses done next cycle, and goes HALT.
- Redirect (highest priority after rst):
  - pc<=redirect_target and instr_valid<=0. The held wrong-path slot is flushed; no fetch that cycle.
  - The state is unchanged, so redirect works in HALT too. In that case the next start/step fetches the target.
  - A target >= PROG_LEN is clamped to 0.
- pc arithmetic is 8-bit. pc never exceeds PROG_LEN-1.
- Priority: rst > redirect_valid > halt_req > start > step > fetch.
- Reset mid-operation: all state is discarded in one cycle, and any in-flight instruction is dropped.

## Timing
- Reset values: pc=0, state HALT, instr=0, instr_pc=0, instr_valid=0, running=0, done=0, bp_hit=0.
- rom_addr is combinational from pc.
- Fetch latency: 1 cycle from the fetch edge to instr_valid.
- Sustained throughput: 1 instruction/cycle with instr_ready held high.
- Redirect penalty: 1 bubble cycle. The target instruction is valid 2 cycles after the redirect edge.
- start to first instr_valid: 2 cycles (1 cycle to enter RUN, 1 cycle to fetch).
- running is registered from the state. done and bp_hit are registered one-cycle pulses.

## Configuration
- FETCH_SEQ_BKPT_EN defined:
  - Adds the bp_en, bp_addr and bp_hit ports.
  - In RUN, when bp_en & pc==bp_addr and a fetch would occur, the fetch is suppressed, the state goes HALT, and bp_hit pulses next cycle.
  - The first fetch after a start or step ignores the breakpoint, so resume proceeds past it.
  - A redirect landing on bp_addr triggers on the next fetch attempt.
- Undefined: the ports are absent and the block contains no breakpoint logic.

## Test plan
- Free run, ROM lines 0..3 = 8B,86,19,34, PROG_LEN=4, instr_ready=1, start pulse:
  - instr sequence is 8B,86,19,34 on consecutive cycles, with instr_pc 0..3.
  - done pulses one cycle after 34 is valid; the block is then in HALT with pc=0.
- Backpressure: instr_ready=0 for 3 cycles while instr=86 is held.
  - instr and instr_pc=1 stay stable, and pc stays at 2.
  - After instr_ready=1, the next instruction is 19 with no loss or duplicate.
- Redirect: consume instr_pc=6 with redirect_valid=1 and target=4.
  - The next cycle has instr_valid=0 (line 7 is never presented).
  - The following cycle presents instr_pc=4.
- Step and halt:
  - From HALT, a step pulse yields exactly one instruction, then HALT.
  - halt_req asserted in RUN stops fetching the same cycle, and the held instr stays valid until consumed.
- Reset mid-stream: rst asserted while instr_valid=1 and pc=5.
  - The next cycle shows instr_valid=0, pc=0, running=0, instr=0.
- FETCH_SEQ_BKPT_EN, bp_addr=2, bp_en=1, start:
  - Lines 0 and 1 are fetched, bp_hit pulses, and the block is in HALT with pc=2.
  - A second start fetches line 2 and continues.
